// File: rtl/codeword_packer_pkg.sv
// Shared stage-1 package: encoded-type enum, codeword length
// constants and the packer FSM state type.
package codeword_packer_pkg;

    localparam int CW_LEN_2   = 2;
    localparam int CW_LEN_6   = 6;
    localparam int CW_LEN_12  = 12;
    localparam int CW_LEN_16  = 16;
    localparam int CW_LEN_24  = 24;
    localparam int CW_LEN_34  = 34;
    localparam int CW_MAX_LEN = CW_LEN_34;

    typedef enum logic [2:0] {
        ENC_NONE = 3'd0,
        ENC_L2   = 3'd1,
        ENC_L6   = 3'd2,
        ENC_L12  = 3'd3,
        ENC_L16  = 3'd4,
        ENC_L24  = 3'd5,
        ENC_L34  = 3'd6
    } enc_type_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } pack_state_t;

    function automatic logic [5:0] enc_len(enc_type_t t);
        logic [5:0] l;
        l = 6'd0;
        case (t)
            ENC_L2:  l = 6'(CW_LEN_2);
            ENC_L6:  l = 6'(CW_LEN_6);
            ENC_L12: l = 6'(CW_LEN_12);
            ENC_L16: l = 6'(CW_LEN_16);
            ENC_L24: l = 6'(CW_LEN_24);
            ENC_L34: l = 6'(CW_LEN_34);
            default: l = 6'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/codeword_align.sv
// Masks a right-aligned codeword and barrel-shifts it so its MSB
// lands just below the current fill of an MSB-justified accumulator.
module codeword_align
    import codeword_packer_pkg::*;
#(
    parameter int MAX_LEN = CW_MAX_LEN,
    parameter int BUF_W   = 66,
    parameter int FILL_W  = 7
) (
    input  logic [MAX_LEN-1:0] code,
    input  logic [5:0]         length,
    input  logic [FILL_W-1:0]  fill,
    output logic [BUF_W-1:0]   aligned
);

    logic [MAX_LEN-1:0] masked;
    logic [7:0]         shamt;

    // Drop bits at/above length, then shift up by BUF_W-fill-length.
    always_comb begin
        masked  = code & ~({MAX_LEN{1'b1}} << length);
        shamt   = 8'(BUF_W) - 8'(fill) - 8'(length);
        aligned = {{(BUF_W-MAX_LEN){1'b0}}, masked} << shamt;
    end

endmodule

// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into fixed-width words,
// with an explicit flush that emits a zero-padded final word.
module codeword_packer
    import codeword_packer_pkg::*;
#(
    parameter int OUT_W   = 32,
    parameter int MAX_LEN = CW_MAX_LEN
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [MAX_LEN-1:0] i_code,
    input  logic [5:0]         i_length,
    input  logic               i_flush,
    output logic [OUT_W-1:0]   o_word,
    output logic               o_word_valid,
    input  logic               i_word_ready,
    output logic [5:0]         o_word_bits,
    output logic               o_last,
    output logic               o_flush_done,
    output logic               o_err,
    output logic [31:0]        o_total_bits
);

    localparam int BUF_W  = OUT_W + MAX_LEN;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(OUT_W);

    pack_state_t       state;
    pack_state_t       state_n;
    logic [BUF_W-1:0]  acc;
    logic [BUF_W-1:0]  aligned;
    logic [FILL_W-1:0] fill;
    logic              out_free;
    logic              accept;
    logic              len_ok;
    logic              emit_full;
    logic              emit_part;

    codeword_align #(
        .MAX_LEN (MAX_LEN),
        .BUF_W   (BUF_W),
        .FILL_W  (FILL_W)
    ) u_align (
        .code    (i_code),
        .length  (i_length),
        .fill    (fill),
        .aligned (aligned)
    );

    // Handshake and emit qualifiers, all from registered fill/state.
    always_comb begin
        out_free  = !o_word_valid || i_word_ready;
        accept    = i_valid && o_ready;
        len_ok    = (i_length != 6'd0) && (int'(i_length) <= MAX_LEN);
        emit_full = (fill >= FILL_OUT) && out_free;
        emit_part = (state == ST_FLUSH) && (fill != '0)
                 && (fill < FILL_OUT) && out_free;
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_RUN;
        else          state <= state_n;
    end

    // FSM next state: leave FLUSH once the last bits are out.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_RUN:   if (i_flush) state_n = ST_FLUSH;
            ST_FLUSH: if ((fill == '0) || emit_part
                          || (emit_full && (fill == FILL_OUT)))
                          state_n = ST_DONE;
            ST_DONE:  state_n = ST_RUN;
            default:  state_n = ST_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_ready      = (state == ST_RUN) && (fill < FILL_OUT);
        o_flush_done = (state == ST_DONE);
    end

    // Accumulator: append legal codewords, shift out emitted words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc  <= '0;
            fill <= '0;
        end else if (accept && len_ok) begin
            acc  <= acc | aligned;
            fill <= fill + FILL_W'(i_length);
        end else if (emit_full) begin
            acc  <= acc << OUT_W;
            fill <= fill - FILL_OUT;
        end else if (emit_part) begin
            acc  <= '0;
            fill <= '0;
        end
    end

    // Output word register, held until the consumer takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_word_bits  <= '0;
            o_last       <= 1'b0;
        end else if (emit_full) begin
            o_word       <= acc[BUF_W-1 -: OUT_W];
            o_word_valid <= 1'b1;
            o_word_bits  <= 6'(OUT_W);
            o_last       <= (state == ST_FLUSH) && (fill == FILL_OUT);
        end else if (emit_part) begin
            o_word       <= acc[BUF_W-1 -: OUT_W];
            o_word_valid <= 1'b1;
            o_word_bits  <= fill[5:0];
            o_last       <= 1'b1;
        end else if (i_word_ready) begin
            o_word_valid <= 1'b0;
        end
    end

    // Sticky illegal-length flag and accepted-bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err        <= 1'b0;
            o_total_bits <= '0;
        end else begin
            if (accept && !len_ok)
                o_err <= 1'b1;
            if (state == ST_DONE)
                o_total_bits <= '0;
            else if (accept && len_ok)
                o_total_bits <= o_total_bits + 32'(i_length);
        end
    end

endmodule
